dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//   Shares the single-port data-memory BRAM between two requesters: the CPU MEM stage (port C) and the
//   debug/program loader (port D). Each access uses a req/ack handshake with fair round-robin arbitration.
//   cpu_stall is driven while a CPU access is outstanding, so the pipeline holds until the access completes.
//   Sits between MEM, the loader and the BRAM.
// PARAMETERS
//   ADDR_W  14  BRAM word-address width (depth 2**ADDR_W words)
//   DATA_W  32  data width
//   RD_LAT  1   BRAM read latency in cycles, >=1
// PORTS
//   clk        in   1       system clock (clk_wiz output)
//   rst        in   1       reset, asynchronous, active-high
//   cpu_req    in   1       CPU access request; held with we/addr/wdata until cpu_ack
//   cpu_we     in   1       1=write, 0=read
//   cpu_addr   in   32      byte address
//   cpu_wdata  in   DATA_W  write data
//   cpu_rdata  out  DATA_W  read data; valid in cpu_ack cycle
//   cpu_ack    out  1       one-cycle completion pulse
//   cpu_err    out  1       with ack: access rejected (misaligned/out of range)
//   cpu_stall  out  1       cpu_req & ~cpu_ack (combinational)
//   dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack, dbg_err : same as cpu_* for port D
//   mem_en     out  1       BRAM enable
//   mem_we     out  1       BRAM write enable
//   mem_addr   out  ADDR_W  BRAM word address
//   mem_wdata  out  DATA_W  BRAM write data
//   mem_rdata  in   DATA_W  BRAM read data, RD_LAT cycles after the enable cycle
// BEHAVIOUR
//   - Reset (async): state=IDLE; last=D (CPU wins the first tie).
//     All outputs 0 except cpu_stall, which follows cpu_req.
//   - States: IDLE, ISSUE, WAIT, DONE. All outputs except cpu_stall are registered.
//   - IDLE: sample requests at the clock edge.
//       none -> IDLE.
//       one -> grant it.
//       both -> grant the port that is not 'last'; last := granted port.
//     Latch the granted port's we/addr/wdata internally.
//     Word index = addr[ADDR_W+1:2].
//     If addr[1:0]!=0 or addr[31:ADDR_W+2]!=0 -> DONE with err=1; no BRAM access.
//     Otherwise -> ISSUE.
//   - ISSUE (1 cycle): mem_en=1, mem_we=latched we, mem_addr/mem_wdata from the latched values.
//       write -> DONE.
//       read -> WAIT with count=RD_LAT.
//   - WAIT: count decrements each cycle. At count==1, load mem_rdata into the granted port's rdata register, then -> DONE.
//   - DONE (1 cycle): granted port's ack=1 and err as decided; other port's ack=0. Next state IDLE.
//     Requests are not sampled in DONE, so a requester can drop or replace req after ack.
//   - Latency: request seen at edge N; ack during cycle N+2 (write), N+2+RD_LAT (read), or N+1 (error).
//   - x_rdata holds its last read value until the next successful read on that port.
//     err and write completions do not modify it.
//   - mem_en/mem_we are 0 in every state except ISSUE; never asserted for rejected accesses.
//   - A requester dropping req before ack is a protocol violation. The access completes anyway; the ack is still issued.
//   - The waiting port keeps priority: after any grant, 'last' flips, so with both requesting continuously grants alternate C,D,C,D.
//   - A single requester receives back-to-back grants (no idle penalty beyond the IDLE cycle).
//   - rst during ISSUE/WAIT/DONE: abort immediately to IDLE; no ack; mem_en/mem_we drop asynchronously.
//     An in-flight write may or may not land; the bench does not check it.
// TESTING
//   1 Reset: assert rst mid-WAIT with cpu_req=1.
//     -> all acks/mem_en go 0 at once, cpu_stall=1, state IDLE.
//     After release, the read completes normally.
//   2 CPU write then read: cpu write addr=0x0000_0010, wdata=0xDEADBEEF.
//     -> mem_addr=4, mem_we=1 in cycle N+1, cpu_ack in N+2.
//     Then read of the same address -> cpu_rdata=0xDEADBEEF, ack in N+3 (RD_LAT=1).
//   3 Contention: cpu_req and dbg_req both held from reset, 4 accesses each.
//     -> grant order C,D,C,D,...; no overlapping acks.
//     cpu_stall high except in cpu_ack cycles.
//   4 Misaligned and out-of-range accesses.
//     cpu read addr=0x0000_0002 -> cpu_ack+cpu_err in cycle N+1, mem_en never 1, cpu_rdata unchanged.
//     dbg write addr=0x0001_0000 (ADDR_W=14) -> dbg_err=1, BRAM unmodified.
//   5 RD_LAT=3 build: dbg read.
//     -> ack in cycle N+5, with data equal to mem_rdata three cycles after ISSUE.
//   6 Single requester streaming: 10 consecutive dbg writes to incrementing addresses.
//     -> one write completes every 3 cycles; readback by CPU matches all 10.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data-memory BRAM between the CPU MEM
// stage (port C) and the debug/program loader (port D). Each port uses a
// req/ack handshake. Round-robin arbitration alternates grants when both ports
// are requesting. Every output except cpu_stall is driven from a register.
module dmem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // Port identifiers: 0 selects the CPU, 1 selects the loader.
    localparam logic PORT_C = 1'b0;

    state_t            state, state_n;
    logic              last, last_n;
    logic              gnt, gnt_n;
    logic              lat_we, we_n;
    logic [ADDR_W-1:0] lat_addr, addr_n;
    logic [DATA_W-1:0] lat_wdata, wdata_n;
    logic              lat_err, err_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [DATA_W-1:0] cpu_rdata_n, dbg_rdata_n;

    logic              pick_dbg;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              bad;

    // The CPU pipeline must hold whenever its request has not yet been acknowledged.
    assign cpu_stall = cpu_req & ~cpu_ack;

    // Next-state logic: arbitrate and latch a request in IDLE, then walk the access through ISSUE/WAIT/DONE.
    always_comb begin
        state_n     = state;
        last_n      = last;
        gnt_n       = gnt;
        we_n        = lat_we;
        addr_n      = lat_addr;
        wdata_n     = lat_wdata;
        err_n       = lat_err;
        cnt_n       = cnt;
        cpu_rdata_n = cpu_rdata;
        dbg_rdata_n = dbg_rdata;
        pick_dbg    = 1'b0;
        sel_we      = 1'b0;
        sel_addr    = '0;
        sel_wdata   = '0;
        bad         = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    // On a tie the port that did not win last time gets the grant.
                    pick_dbg  = (cpu_req && dbg_req) ? (last == PORT_C) : dbg_req;
                    sel_we    = pick_dbg ? dbg_we    : cpu_we;
                    sel_addr  = pick_dbg ? dbg_addr  : cpu_addr;
                    sel_wdata = pick_dbg ? dbg_wdata : cpu_wdata;
                    bad       = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_W+2] != '0);
                    gnt_n     = pick_dbg;
                    last_n    = pick_dbg;
                    we_n      = sel_we;
                    addr_n    = sel_addr[ADDR_W+1:2];
                    wdata_n   = sel_wdata;
                    err_n     = bad;
                    state_n   = bad ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (lat_we) begin
                    state_n = DONE;
                end else begin
                    state_n = WAIT;
                    cnt_n   = CNT_W'(RD_LAT);
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    if (gnt == PORT_C) begin
                        cpu_rdata_n = mem_rdata;
                    end else begin
                        dbg_rdata_n = mem_rdata;
                    end
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register plus the latched request; reset makes the CPU win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            gnt       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            gnt       <= gnt_n;
            lat_we    <= we_n;
            lat_addr  <= addr_n;
            lat_wdata <= wdata_n;
            lat_err   <= err_n;
            cnt       <= cnt_n;
        end
    end

    // Registered outputs decoded from the upcoming state, so BRAM strobes and acks line up with ISSUE and DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            dbg_ack   <= 1'b0;
            dbg_err   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            mem_en    <= (state_n == ISSUE);
            mem_we    <= (state_n == ISSUE) && we_n;
            if (state_n == ISSUE) begin
                mem_addr  <= addr_n;
                mem_wdata <= wdata_n;
            end
            cpu_ack   <= (state_n == DONE) && (gnt_n == PORT_C);
            cpu_err   <= (state_n == DONE) && (gnt_n == PORT_C) && err_n;
            dbg_ack   <= (state_n == DONE) && (gnt_n != PORT_C);
            dbg_err   <= (state_n == DONE) && (gnt_n != PORT_C) && err_n;
            cpu_rdata <= cpu_rdata_n;
            dbg_rdata <= dbg_rdata_n;
        end
    end

endmodule
